paddle_ctrl: RTL and testbench



---
 rtl/paddle_ctrl_pkg.sv | 19 +
 rtl/paddle_ctrl_if.sv | 31 +++
 rtl/button_debounce.sv | 52 +++++
 rtl/paddle_ctrl.sv | 108 ++++++++++
 tb/tb_paddle_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/paddle_ctrl_pkg.sv
// Shared definitions for the paddle controller: movement direction encoding
// and the default screen/paddle geometry used as parameter defaults.
package paddle_ctrl_pkg;

  typedef enum logic [1:0] {
    DirIdle = 2'd0,
    DirUp   = 2'd1,
    DirDown = 2'd2
  } dir_e;

  localparam int unsigned DefNumPaddles = 2;
  localparam int unsigned DefPosW       = 10;
  localparam int unsigned DefScreenH    = 480;
  localparam int unsigned DefPaddleH    = 80;
  localparam int unsigned DefStep       = 4;
  localparam int unsigned DefDeadband   = 4;
  localparam int unsigned DefDbCycles   = 250000;

endpackage

// File: rtl/paddle_ctrl_if.sv
// Game-side bundle of the paddle controller.
//   master: frame/button/mode/ball inputs out, paddle positions and flags in
//   slave : the controller end (paddle_ctrl)
// paddle_y packs paddle i top edge at [i*POS_W +: POS_W].
interface paddle_ctrl_if
  import paddle_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PADDLES = DefNumPaddles,
  parameter int unsigned POS_W       = DefPosW
) ();

  logic                         frame_tick;
  logic [NUM_PADDLES-1:0]       btn_up;
  logic [NUM_PADDLES-1:0]       btn_down;
  logic [NUM_PADDLES-1:0]       auto_en;
  logic [POS_W-1:0]             ball_y;
  logic [NUM_PADDLES*POS_W-1:0] paddle_y;
  logic [NUM_PADDLES-1:0]       at_top;
  logic [NUM_PADDLES-1:0]       at_bottom;

  modport master (
    output frame_tick, btn_up, btn_down, auto_en, ball_y,
    input  paddle_y, at_top, at_bottom
  );

  modport slave (
    input  frame_tick, btn_up, btn_down, auto_en, ball_y,
    output paddle_y, at_top, at_bottom
  );

endinterface

// File: rtl/button_debounce.sv
// Two-flop synchroniser followed by a counter debouncer for one raw button.
//   clock, reset : system clock, synchronous active-high reset
//   raw          : asynchronous button level
//   level        : debounced level; flips after DB_CYCLES consecutive
//                  synchronised samples that disagree with it
module button_debounce
  import paddle_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DefDbCycles
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int unsigned CntW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any sample agreeing with the current level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(DB_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  assign level = level_q;

endmodule

// File: rtl/paddle_ctrl.sv
// Multi-paddle position controller for the VGA game path. Buttons are
// debounced, each paddle steps at most once per frame_tick (landing the
// cycle after the tick) and saturates at the screen bounds. In auto mode a
// paddle follows ball_y with a deadband and ignores its buttons.
//   clock, reset : system clock, synchronous active-high reset
//   bus          : paddle_ctrl_if slave (inputs, packed paddle_y, flags)
module paddle_ctrl
  import paddle_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PADDLES = DefNumPaddles,
  parameter int unsigned POS_W       = DefPosW,
  parameter int unsigned SCREEN_H    = DefScreenH,
  parameter int unsigned PADDLE_H    = DefPaddleH,
  parameter int unsigned STEP        = DefStep,
  parameter int unsigned DEADBAND    = DefDeadband,
  parameter int unsigned DB_CYCLES   = DefDbCycles
) (
  input logic          clock,
  input logic          reset,
  paddle_ctrl_if.slave bus
);

  // Extended width so bound and centre arithmetic cannot wrap.
  localparam int unsigned ExtW = POS_W + 1;
  localparam logic [ExtW-1:0]  MaxY    = ExtW'(SCREEN_H - PADDLE_H);
  localparam logic [ExtW-1:0]  StepExt = ExtW'(STEP);
  localparam logic [ExtW-1:0]  HalfH   = ExtW'(PADDLE_H / 2);
  localparam logic [ExtW-1:0]  DeadExt = ExtW'(DEADBAND);
  localparam logic [POS_W-1:0] CentreY = POS_W'((SCREEN_H - PADDLE_H) / 2);

  logic [NUM_PADDLES-1:0]            up_lvl, dn_lvl;
  logic [NUM_PADDLES-1:0][POS_W-1:0] pos_q;
  logic [NUM_PADDLES-1:0]            top_q, bot_q;

  for (genvar i = 0; i < NUM_PADDLES; i++) begin : g_paddle
    dir_e             dir;
    logic [ExtW-1:0]  y_ext, centre, ball_ext, sum_down;
    logic [POS_W-1:0] pos_d;

    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
      .clock (clock),
      .reset (reset),
      .raw   (bus.btn_up[i]),
      .level (up_lvl[i])
    );

    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_down (
      .clock (clock),
      .reset (reset),
      .raw   (bus.btn_down[i]),
      .level (dn_lvl[i])
    );

    always_ff @(posedge clock) begin
      if (reset) begin
        pos_q[i] <= CentreY;
        top_q[i] <= 1'b0;
        bot_q[i] <= 1'b0;
      end else begin
        pos_q[i] <= pos_d;
        top_q[i] <= (pos_d == '0);
        bot_q[i] <= ({1'b0, pos_d} == MaxY);
      end
    end

    // Direction request; only consumed on the frame_tick cycle.
    always_comb begin
      dir      = DirIdle;
      y_ext    = {1'b0, pos_q[i]};
      centre   = y_ext + HalfH;
      ball_ext = {1'b0, bus.ball_y};
      if (bus.auto_en[i]) begin
        if (ball_ext + DeadExt < centre) begin
          dir = DirUp;
        end else if (ball_ext > centre + DeadExt) begin
          dir = DirDown;
        end
      end else begin
        unique case ({up_lvl[i], dn_lvl[i]})
          2'b10:   dir = DirUp;
          2'b01:   dir = DirDown;
          default: dir = DirIdle;
        endcase
      end
    end

    always_comb begin
      pos_d    = pos_q[i];
      sum_down = {1'b0, pos_q[i]} + StepExt;
      if (bus.frame_tick) begin
        unique case (dir)
          DirUp: begin
            pos_d = ({1'b0, pos_q[i]} < StepExt) ? '0 : pos_q[i] - StepExt[POS_W-1:0];
          end
          DirDown: begin
            pos_d = (sum_down > MaxY) ? MaxY[POS_W-1:0] : sum_down[POS_W-1:0];
          end
          default: pos_d = pos_q[i];
        endcase
      end
    end
  end

  assign bus.paddle_y  = pos_q;
  assign bus.at_top    = top_q;
  assign bus.at_bottom = bot_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl with DB_CYCLES = 8. A behavioural model (sliding
// window debounce, integer min/max position rules) steps alongside the DUT
// every cycle; scenario tasks check fixed expected positions, the random
// task checks the DUT against the model.
module tb_paddle_ctrl;

  localparam int NP    = 2;
  localparam int PW    = 10;
  localparam int DB    = 8;
  localparam int SH    = 480;
  localparam int PH    = 80;
  localparam int STEPV = 4;
  localparam int DBAND = 4;
  localparam int MAXY  = SH - PH;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  paddle_ctrl_if #(.NUM_PADDLES(NP), .POS_W(PW)) bus ();

  paddle_ctrl #(
    .NUM_PADDLES (NP),
    .POS_W       (PW),
    .SCREEN_H    (SH),
    .PADDLE_H    (PH),
    .STEP        (STEPV),
    .DEADBAND    (DBAND),
    .DB_CYCLES   (DB)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state. Button index b: up of paddle b (b < NP),
  // down of paddle b-NP otherwise.
  int m_y[NP];
  bit m_lvl[2*NP];
  bit m_pipe[2*NP][2];
  bit m_win[2*NP][DB];
  int m_nwin[2*NP];

  function automatic int dut_y(int i);
    return int'(bus.paddle_y[i*PW +: PW]);
  endfunction

  function automatic bit raw_bit(int b);
    return (b < NP) ? bus.btn_up[b] : bus.btn_down[b-NP];
  endfunction

  // Model update for the coming clock edge, from the inputs applied now.
  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < NP; i++) m_y[i] = MAXY / 2;
      for (int b = 0; b < 2*NP; b++) begin
        m_lvl[b] = 0; m_pipe[b][0] = 0; m_pipe[b][1] = 0; m_nwin[b] = 0;
      end
    end else begin
      if (bus.frame_tick) begin
        for (int i = 0; i < NP; i++) begin
          int d;
          d = 0;
          if (bus.auto_en[i]) begin
            int c, by;
            c  = m_y[i] + PH / 2;
            by = int'(bus.ball_y);
            if (by + DBAND < c) d = 1;
            else if (by > c + DBAND) d = 2;
          end else if (m_lvl[i] && !m_lvl[NP+i]) d = 1;
          else if (!m_lvl[i] && m_lvl[NP+i]) d = 2;
          if (d == 1) m_y[i] = (m_y[i] - STEPV < 0) ? 0 : m_y[i] - STEPV;
          if (d == 2) m_y[i] = (m_y[i] + STEPV > MAXY) ? MAXY : m_y[i] + STEPV;
        end
      end
      for (int b = 0; b < 2*NP; b++) begin
        bit seen, all_diff;
        seen = m_pipe[b][0];
        m_pipe[b][0] = m_pipe[b][1];
        m_pipe[b][1] = raw_bit(b);
        for (int j = 0; j < DB - 1; j++) m_win[b][j] = m_win[b][j+1];
        m_win[b][DB-1] = seen;
        if (m_nwin[b] < DB) m_nwin[b]++;
        if (m_nwin[b] == DB) begin
          all_diff = 1;
          for (int j = 0; j < DB; j++) if (m_win[b][j] == m_lvl[b]) all_diff = 0;
          if (all_diff) begin
            m_lvl[b]  = !m_lvl[b];
            m_nwin[b] = 0;
          end
        end
      end
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    cycle();
    bus.frame_tick = 1'b0;
    cycle();
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.frame_tick = 1'b0; bus.btn_up = '0; bus.btn_down = '0;
    bus.auto_en = '0; bus.ball_y = '0;
    cycle();
    // Coincident tick with auto tracking towards 0 must lose to reset.
    bus.frame_tick = 1'b1; bus.auto_en = '1;
    cycle();
    reset = 1'b0; bus.frame_tick = 1'b0; bus.auto_en = '0;
    for (int i = 0; i < NP; i++) begin
      total++;
      if (dut_y(i) !== 200) begin
        bad++; $display("FAIL reset_y%0d: got %0d expected 200", i, dut_y(i));
      end
    end
    total++;
    if (bus.at_top !== 2'b00) begin
      bad++; $display("FAIL reset_at_top: got %b expected 00", bus.at_top);
    end
    total++;
    if (bus.at_bottom !== 2'b00) begin
      bad++; $display("FAIL reset_at_bottom: got %b expected 00", bus.at_bottom);
    end
  endtask

  task automatic test_manual_up();
    bus.btn_up[0] = 1'b1;
    idle(9);
    // Level has not yet flipped on this tick cycle: no move.
    tick();
    total++;
    if (dut_y(0) !== 200) begin
      bad++; $display("FAIL debounce_edge: got %0d expected 200", dut_y(0));
    end
    for (int k = 0; k < 10; k++) begin
      bus.frame_tick = 1'b1;
      cycle();
      bus.frame_tick = 1'b0;
      total++;
      if (dut_y(0) !== 200 - STEPV * (k + 1)) begin
        bad++; $display("FAIL up_tick%0d: got %0d expected %0d", k, dut_y(0), 200 - 4*(k+1));
      end
      cycle();
    end
    total++;
    if (dut_y(1) !== 200) begin
      bad++; $display("FAIL up_other_paddle: got %0d expected 200", dut_y(1));
    end
    bus.btn_up[0] = 1'b0;
    idle(12);
  endtask

  task automatic test_glitch();
    bus.btn_down[1] = 1'b1;
    idle(3);
    bus.btn_down[1] = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    total++;
    if (dut_y(1) !== 200) begin
      bad++; $display("FAIL glitch_y1: got %0d expected 200", dut_y(1));
    end
    total++;
    if (dut_y(0) !== 160) begin
      bad++; $display("FAIL glitch_y0: got %0d expected 160", dut_y(0));
    end
  endtask

  task automatic test_saturate();
    int exp_y;
    bus.btn_down[0] = 1'b1;
    idle(10);
    for (int k = 0; k < 120; k++) begin
      tick();
      exp_y = (160 + STEPV * (k + 1) > MAXY) ? MAXY : 160 + STEPV * (k + 1);
      total++;
      if (dut_y(0) !== exp_y) begin
        bad++; $display("FAIL down_tick%0d: got %0d expected %0d", k, dut_y(0), exp_y);
      end
    end
    total++;
    if (bus.at_bottom !== 2'b01) begin
      bad++; $display("FAIL at_bottom: got %b expected 01", bus.at_bottom);
    end
    bus.btn_down[0] = 1'b0;
    idle(12);
    bus.btn_up[0] = 1'b1;
    idle(10);
    for (int k = 0; k < 105; k++) begin
      tick();
      exp_y = (MAXY - STEPV * (k + 1) < 0) ? 0 : MAXY - STEPV * (k + 1);
      total++;
      if (dut_y(0) !== exp_y) begin
        bad++; $display("FAIL up_tick%0d: got %0d expected %0d", k, dut_y(0), exp_y);
      end
      total++;
      if (bus.at_top[0] !== (exp_y == 0)) begin
        bad++; $display("FAIL at_top_tick%0d: got %b expected %b", k, bus.at_top[0], exp_y == 0);
      end
    end
    total++;
    if (bus.at_bottom !== 2'b00) begin
      bad++; $display("FAIL at_bottom_clear: got %b expected 00", bus.at_bottom);
    end
    bus.btn_up[0] = 1'b0;
    idle(12);
  endtask

  task automatic test_auto();
    int exp_y;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    bus.auto_en[0] = 1'b1;
    bus.ball_y = 10'd100;
    exp_y = 200;
    for (int k = 0; k < 40; k++) begin
      bus.btn_up[0] = 1'($urandom); bus.btn_down[0] = 1'($urandom);
      bus.frame_tick = 1'b1;
      cycle();
      bus.frame_tick = 1'b0;
      bus.btn_up[0] = 1'($urandom); bus.btn_down[0] = 1'($urandom);
      cycle();
      exp_y = (200 - STEPV * (k + 1) < 64) ? 64 : 200 - STEPV * (k + 1);
      total++;
      if (dut_y(0) !== exp_y) begin
        bad++; $display("FAIL auto_up%0d: got %0d expected %0d", k, dut_y(0), exp_y);
      end
    end
    bus.ball_y = 10'd300;
    for (int k = 0; k < 60; k++) begin
      tick();
      exp_y = (64 + STEPV * (k + 1) > 256) ? 256 : 64 + STEPV * (k + 1);
      total++;
      if (dut_y(0) !== exp_y) begin
        bad++; $display("FAIL auto_down%0d: got %0d expected %0d", k, dut_y(0), exp_y);
      end
    end
    // Ball/mode wiggle between ticks has no effect.
    bus.ball_y = 10'd0; bus.auto_en[0] = 1'b0;
    idle(3);
    bus.ball_y = 10'd300; bus.auto_en[0] = 1'b1;
    tick();
    total++;
    if (dut_y(0) !== 256) begin
      bad++; $display("FAIL auto_hold: got %0d expected 256", dut_y(0));
    end
    bus.auto_en[0] = 1'b0; bus.btn_up[0] = 1'b0; bus.btn_down[0] = 1'b0;
    idle(12);
  endtask

  task automatic test_both_reset();
    bus.btn_up[1] = 1'b1; bus.btn_down[1] = 1'b1;
    idle(10);
    for (int k = 0; k < 5; k++) tick();
    total++;
    if (dut_y(1) !== 200) begin
      bad++; $display("FAIL both_held: got %0d expected 200", dut_y(1));
    end
    reset = 1'b1; bus.btn_up[1] = 1'b0;
    cycle();
    reset = 1'b0;
    total++;
    if (dut_y(0) !== 200) begin
      bad++; $display("FAIL midhold_reset_y0: got %0d expected 200", dut_y(0));
    end
    idle(9);
    tick();
    total++;
    if (dut_y(1) !== 200) begin
      bad++; $display("FAIL fresh_debounce_early: got %0d expected 200", dut_y(1));
    end
    tick();
    total++;
    if (dut_y(1) !== 204) begin
      bad++; $display("FAIL fresh_debounce_move: got %0d expected 204", dut_y(1));
    end
    bus.btn_down[1] = 1'b0;
    idle(12);
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        int b;
        b = $urandom_range(0, 2*NP - 1);
        if (b < NP) bus.btn_up[b] = ~bus.btn_up[b];
        else bus.btn_down[b-NP] = ~bus.btn_down[b-NP];
      end
      if ($urandom_range(0, 63) == 0) begin
        int a;
        a = $urandom_range(0, NP - 1);
        bus.auto_en[a] = ~bus.auto_en[a];
      end
      if ($urandom_range(0, 7) == 0) bus.ball_y = PW'($urandom_range(0, SH - 1));
      bus.frame_tick = ($urandom_range(0, 3) == 0);
      cycle();
      for (int i = 0; i < NP; i++) begin
        total++;
        if (dut_y(i) !== m_y[i]) begin
          bad++; $display("FAIL rand_y%0d@%0d: got %0d expected %0d", i, n, dut_y(i), m_y[i]);
        end
        total++;
        if (bus.at_top[i] !== (m_y[i] == 0) || bus.at_bottom[i] !== (m_y[i] == MAXY)) begin
          bad++;
          $display("FAIL rand_flags%0d@%0d: got top=%b bot=%b expected top=%b bot=%b", i, n,
                   bus.at_top[i], bus.at_bottom[i], m_y[i] == 0, m_y[i] == MAXY);
        end
      end
    end
    bus.frame_tick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_manual_up();
    test_glitch();
    test_saturate();
    test_auto();
    test_both_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
